// File: rtl/uart_hex_dumper.sv
// uart_hex_dumper
//   Buffers raw bytes from the MAC datapath in a small FIFO and prints each one
//   as two uppercase ASCII hex characters. Bytes are separated by a space. A
//   CR LF is inserted after the last byte of a frame and after every
//   BYTES_PER_LINE bytes. Characters go to uart_debug, which has no ready
//   signal, so successive strobes are spaced GAP = (CLK_FREQ/BAUD_RATE+1)*11
//   cycles apart. That spacing always lets the transmitter finish a character.
//
// Optional feature (compile-time macro UART_HEX_DROP_MARK_EN):
//   When defined, a dropped byte is reported in the output stream as "!\r\n"
//   before the next byte is printed, and overflow clears when the '!' is sent.
//   When undefined, overflow is sticky until reset.
//
// Ports
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   byte_in     in   8  data byte to dump
//   byte_valid  in   1  write strobe, one byte per cycle
//   frame_end   in   1  byte_in is the last byte of a frame
//   fifo_full   out  1  FIFO holds FIFO_DEPTH entries (registered)
//   overflow    out  1  at least one byte was dropped
//   uart_data   out  8  ASCII character to uart_debug.data_in
//   uart_valid  out  1  one-cycle strobe to uart_debug.valid_in
module uart_hex_dumper #(
  parameter int BAUD_RATE      = 115200,
  parameter int CLK_FREQ       = 100000000,
  parameter int FIFO_DEPTH     = 16,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       frame_end,
  output logic       fifo_full,
  output logic       overflow,
  output logic [7:0] uart_data,
  output logic       uart_valid
);

  localparam int CLK_DIV = CLK_FREQ / BAUD_RATE;
  localparam int GAP     = (CLK_DIV + 1) * 11;
  localparam int TW      = $clog2(GAP);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] GAP_M1    = TW'(GAP - 1);
  localparam logic [7:0]    LINE_MAX  = 8'(BYTES_PER_LINE);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, HI, LO, SEP, CR, LF, WAIT} state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [8:0]    head;

  state_t        state;
  state_t        next_st;
  logic [TW-1:0] timer;
  logic [8:0]    hold;
  logic [7:0]    line_cnt;
  logic [7:0]    line_inc;
  logic          go_idle;
  logic          mark_emit;

  // A write seen while full is dropped even if a pop happens in the same cycle.
  assign push       = byte_valid && !fifo_full;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  // The IDLE decision is also taken on the last WAIT cycle when the next
  // state is IDLE. Back-to-back bytes then stay exactly GAP cycles apart.
  assign go_idle = (state == IDLE) ||
                   ((state == WAIT) && (timer == '0) && (next_st == IDLE));

`ifdef UART_HEX_DROP_MARK_EN
  assign mark_emit = go_idle && overflow;
`else
  assign mark_emit = 1'b0;
`endif

  assign pop      = go_idle && !mark_emit && !fifo_empty;
  assign line_inc = (line_cnt == LINE_MAX) ? line_cnt : line_cnt + 8'd1;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage needs no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {frame_end, byte_in};
  end

  // FIFO pointers, registered full flag and drop flag.
  // A new drop takes priority over the marker clearing overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      fifo_full <= (count_next == DEPTH_CNT);
      if (byte_valid && fifo_full) overflow <= 1'b1;
      else if (mark_emit)          overflow <= 1'b0;
    end
  end

  // Character sequencer. The high nibble is emitted on the same edge as the
  // pop, so HI never sits in the state register. Every emit reloads the timer.
  // WAIT then dispatches on next_st when the timer reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      next_st    <= IDLE;
      timer      <= '0;
      hold       <= '0;
      line_cnt   <= '0;
      uart_data  <= 8'h00;
      uart_valid <= 1'b0;
    end else begin
      uart_valid <= 1'b0;
      if (go_idle) begin
        if (mark_emit) begin
          uart_data  <= 8'h21;
          uart_valid <= 1'b1;
          timer      <= GAP_M1;
          next_st    <= CR;
          state      <= WAIT;
        end else if (pop) begin
          hold       <= head;
          uart_data  <= hex_char(head[7:4]);
          uart_valid <= 1'b1;
          timer      <= GAP_M1;
          next_st    <= LO;
          state      <= WAIT;
        end else begin
          next_st <= IDLE;
          state   <= IDLE;
        end
      end else if (state == WAIT) begin
        if (timer != '0) begin
          timer <= timer - TW'(1);
        end else begin
          uart_valid <= 1'b1;
          timer      <= GAP_M1;
          state      <= WAIT;
          case (next_st)
            LO: begin
              uart_data <= hex_char(hold[3:0]);
              line_cnt  <= line_inc;
              next_st   <= (hold[8] || (line_inc == LINE_MAX)) ? CR : SEP;
            end
            SEP: begin
              uart_data <= 8'h20;
              next_st   <= IDLE;
            end
            CR: begin
              uart_data <= 8'h0D;
              next_st   <= LF;
            end
            LF: begin
              uart_data <= 8'h0A;
              line_cnt  <= '0;
              next_st   <= IDLE;
            end
            default: begin
              uart_valid <= 1'b0;
              next_st    <= IDLE;
              state      <= IDLE;
            end
          endcase
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_dumper.sv
// tb_uart_hex_dumper
//   Directed bench for uart_hex_dumper using CLK_FREQ=1000 and BAUD_RATE=100,
//   so GAP is 121 cycles. FIFO_DEPTH is 4 and BYTES_PER_LINE is 4. A monitor
//   records every uart_valid strobe with its data and cycle number. Tests then
//   compare the recorded stream with hand-computed ASCII.
module tb_uart_hex_dumper;

  localparam int GAP = 121;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       frame_end;
  logic       fifo_full;
  logic       overflow;
  logic [7:0] uart_data;
  logic       uart_valid;

  uart_hex_dumper #(
    .BAUD_RATE(100),
    .CLK_FREQ(1000),
    .FIFO_DEPTH(4),
    .BYTES_PER_LINE(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .frame_end(frame_end),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .uart_data(uart_data),
    .uart_valid(uart_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap_data[$];
  int         cap_cyc[$];

  always @(negedge clk) begin
    if (rst_n && uart_valid) begin
      cap_data.push_back(uart_data);
      cap_cyc.push_back(cyc);
    end
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  int         wr_cyc   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_hi;
    logic [7:0] exp_lo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] capAt(input int i);
    return (i < cap_data.size()) ? {24'h0, cap_data[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic int cycAt(input int i);
    return (i < cap_cyc.size()) ? cap_cyc[i] : -100000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Call just after a rising edge. Drives one byte for exactly one cycle.
  // The task returns just after the next rising edge.
  task automatic applyStimulus(input logic [7:0] b, input logic fe);
    byte_in    = b;
    byte_valid = 1'b1;
    frame_end  = fe;
    wr_cyc     = cyc;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    frame_end  = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearCapture();
    cap_data.delete();
    cap_cyc.delete();
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clearCapture();
    @(posedge clk);
    #1;
  endtask

  task automatic checkStream(input string name);
    checkOutput({name, "_len"}, cap_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      checkOutput($sformatf("%s_chr%0d", name, i), capAt(i), {24'h0, exp_q[i]});
  endtask

  task automatic checkSpacing(input string name);
    for (int i = 1; i < cap_cyc.size(); i++)
      checkOutput($sformatf("%s_gap%0d", name, i), cycAt(i) - cycAt(i - 1), GAP);
  endtask

  initial begin
    int bang_cnt;
    int bang_pos;

    vecs[0] = '{8'hA5, 8'h41, 8'h35};
    vecs[1] = '{8'h00, 8'h30, 8'h30};
    vecs[2] = '{8'hFF, 8'h46, 8'h46};
    vecs[3] = '{8'h3C, 8'h33, 8'h43};
    vecs[4] = '{8'h9A, 8'h39, 8'h41};
    vecs[5] = '{8'h5F, 8'h35, 8'h46};

    rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    frame_end  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_uart_valid", uart_valid, 0);
    checkOutput("rst_uart_data", uart_data, 8'h00);
    checkOutput("rst_fifo_full", fifo_full, 0);
    checkOutput("rst_overflow", overflow, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single byte A5 with frame_end, latency and spacing");
    clearCapture();
    applyStimulus(8'hA5, 1'b1);
    waitCycles(4 * GAP + 60);
    exp_q = '{8'h41, 8'h35, 8'h0D, 8'h0A};
    checkStream("t1");
    checkOutput("t1_latency", cycAt(0) - wr_cyc, 2);
    checkSpacing("t1");
    checkOutput("t1_data_hold", uart_data, 8'h0A);

    $display("[TB] table of single-byte frames");
    for (int i = 0; i < 6; i++) begin
      clearCapture();
      applyStimulus(vecs[i].din, 1'b1);
      waitCycles(4 * GAP + 60);
      exp_q = '{vecs[i].exp_hi, vecs[i].exp_lo, 8'h0D, 8'h0A};
      checkStream($sformatf("vec%0d", i));
    end

    $display("[TB] three bytes back to back");
    doReset();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h1F, 1'b0);
    applyStimulus(8'hFE, 1'b1);
    waitCycles(10 * GAP + 60);
    exp_q = '{8'h30, 8'h30, 8'h20, 8'h31, 8'h46, 8'h20, 8'h46, 8'h45, 8'h0D, 8'h0A};
    checkStream("t2");
    checkSpacing("t2");

    $display("[TB] line wrap after four bytes");
    doReset();
    for (int k = 1; k <= 5; k++) applyStimulus(8'(k), 1'b0);
    waitCycles(18 * GAP);
    exp_q = '{8'h30, 8'h31, 8'h20, 8'h30, 8'h32, 8'h20, 8'h30, 8'h33, 8'h20,
              8'h30, 8'h34, 8'h0D, 8'h0A, 8'h30, 8'h35, 8'h20};
    checkStream("t3");

    $display("[TB] fifo fill and drop");
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(8'(8'h11 * (k + 1)), 1'b0);
      if (k == 3) checkOutput("t4_not_full_yet", fifo_full, 0);
      if (k == 4) begin
        checkOutput("t4_full_after_5th", fifo_full, 1);
        checkOutput("t4_no_overflow_yet", overflow, 0);
      end
    end
    checkOutput("t4_overflow_set", overflow, 1);
    waitCycles(21 * GAP);
`ifdef UART_HEX_DROP_MARK_EN
    bang_cnt = 0;
    bang_pos = -1;
    for (int i = 0; i < cap_data.size(); i++) begin
      if (cap_data[i] == 8'h21) begin
        bang_cnt++;
        bang_pos = i;
      end
    end
    checkOutput("t6_marker_count", bang_cnt, 1);
    checkOutput("t6_marker_cr", capAt(bang_pos + 1), 8'h0D);
    checkOutput("t6_marker_lf", capAt(bang_pos + 2), 8'h0A);
    checkOutput("t6_overflow_cleared", overflow, 0);
`else
    bang_cnt = 0;
    bang_pos = 0;
    exp_q = '{8'h31, 8'h31, 8'h20, 8'h32, 8'h32, 8'h20, 8'h33, 8'h33, 8'h20,
              8'h34, 8'h34, 8'h0D, 8'h0A, 8'h35, 8'h35, 8'h20};
    checkStream("t4");
    checkOutput("t4_overflow_sticky", overflow, 1);
`endif

    $display("[TB] reset in the middle of a character");
    doReset();
    applyStimulus(8'hA5, 1'b1);
    for (int k = 1; k <= 5; k++) applyStimulus(8'(8'h10 + k), 1'b0);
    waitCycles(5);
    checkOutput("t5_first_char", capAt(0), 8'h41);
    checkOutput("t5_overflow_before", overflow, 1);
    checkOutput("t5_full_before", fifo_full, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_valid", uart_valid, 0);
    checkOutput("t5_async_overflow", overflow, 0);
    checkOutput("t5_async_full", fifo_full, 0);
    checkOutput("t5_async_data", uart_data, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clearCapture();
    @(posedge clk);
    #1;
    applyStimulus(8'h3C, 1'b1);
    waitCycles(6 * GAP);
    exp_q = '{8'h33, 8'h43, 8'h0D, 8'h0A};
    checkStream("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
